design_18_issuer: RTL and testbench
===================================

Name: design_18_issuer

Overview:
- Initiator side of the start/a/b → y/valid operation interface exposed by the team's registered-operand arithmetic engines.
- Accepts operand pairs from an upstream valid/ready stream and drives them onto the engine, pulsing start once per operation.
- Waits for the engine's valid with a timeout, then returns the captured result downstream on a valid/ready stream with an error flag.
- Keeps saturating completion and timeout counters for status readback.

Parameters:
- W, 16, operand/result width; must match the engine.
- TIMEOUT, 32, maximum WAIT cycles before an operation is declared failed; must be ≥ 2.
- CW, 16, width of the status counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  issuer can accept an operand pair.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- eng_start  output  1  one-cycle start pulse to the engine.
- eng_a  output  W  operand A to the engine.
- eng_b  output  W  operand B to the engine.
- eng_y  input  W  engine result.
- eng_valid  input  1  engine result valid.
- res_valid  output  1  result available downstream.
- res_ready  input  1  downstream accepts the result.
- res_y  output  W  captured result.
- res_err  output  1  1 = timeout, and res_y is 0.
- done_cnt  output  CW  successful completions, saturating.
- err_cnt  output  CW  timeouts, saturating.
- busy  output  1  state ≠ IDLE.

Behaviour:
- Reset (async assert, sync release): state = IDLE; operand, result and counter registers all 0. Outputs at reset: in_ready=1, eng_start=0, eng_a=eng_b=0, res_valid=0, res_y=0, res_err=0, done_cnt=err_cnt=0, busy=0.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - If in_valid, latch in_a/in_b into the operand registers and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - eng_start=1.
  - Clear wait counter; go to WAIT.
  - eng_valid is ignored in this cycle.
- WAIT:
  - If eng_valid: capture eng_y into res_y, set res_err=0, increment done_cnt (saturating), go to HOLD.
  - Else, if wait counter == TIMEOUT-1: set res_y=0, res_err=1, increment err_cnt (saturating), go to HOLD.
  - Else increment the wait counter.
  - eng_valid in the timeout cycle wins: the result is a success.
- HOLD:
  - res_valid=1; res_y and res_err held stable.
  - On res_ready, go to IDLE. Back-to-back acceptance from HOLD is not allowed; minimum operation period is 4 cycles + engine latency.
- eng_a/eng_b are driven directly from the operand registers. They are stable from ISSUE until the next IDLE acceptance, including through HOLD.
- in_ready=0 in ISSUE, WAIT and HOLD. in_valid in those states has no effect and the upstream data is not consumed.
- Stray eng_valid in IDLE, ISSUE or HOLD is ignored; counters do not change.
- Counters stick at 2^CW−1.
- Reset asserted mid-operation: immediate return to IDLE with all reset values; any pending result is dropped.
- Wait counter width: clog2(TIMEOUT).

Decomposition:
- Shared package `design_18_pkg`:
  - state enum (IDLE, ISSUE, WAIT, HOLD);
  - default TIMEOUT constant;
  - saturating-increment function.
- One natural sub-module, `design_18_issuer_stat`: holds the two saturating counters, driven by done/err pulses from the FSM.
- FSM, operand registers and result registers stay in the top.

Test Plan:
- Single op: in_a=0x0003, in_b=0x0004; engine model returns 0x0007 with eng_valid 2 cycles after eng_start → eng_start high for exactly 1 cycle; res_valid with res_y=0x0007, res_err=0; done_cnt=1.
- Timeout with TIMEOUT=32: engine never asserts valid → res_valid exactly 32 cycles after the WAIT entry; res_err=1, res_y=0; err_cnt=1, done_cnt=0.
- Boundary: eng_valid in the 32nd WAIT cycle carrying 0xBEEF → res_y=0xBEEF, res_err=0, err_cnt unchanged.
- Backpressure: res_ready held 0 for 10 cycles → res_valid, res_y stay stable, in_ready=0, a second in_valid is not consumed; after res_ready=1 the issuer returns to IDLE and accepts the second pair next cycle.
- Reset mid-WAIT: rst_n pulled low while busy → all outputs at reset values immediately (asynchronous); after release the next operation completes normally.
- Saturation with CW=4: 20 successful ops → done_cnt stops at 15; a stray eng_valid in IDLE changes nothing.

Source files
------------

// File: rtl/design_18_pkg.sv
// design_18_pkg: shared state encoding, default timeout and saturating increment
package design_18_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam int TIMEOUT_DEF = 32;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/design_18_issuer_stat.sv
// design_18_issuer_stat: saturating completion and timeout counters
module design_18_issuer_stat
    import design_18_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          done_inc,
    input  logic          err_inc,
    output logic [CW-1:0] done_cnt,
    output logic [CW-1:0] err_cnt
);

    localparam logic [31:0] MAX = 32'({CW{1'b1}});

    logic [CW-1:0] done_q, done_d, err_q, err_d;

    always_comb begin
        done_d = done_inc ? CW'(sat_inc(32'(done_q), MAX)) : done_q;
        err_d  = err_inc  ? CW'(sat_inc(32'(err_q), MAX))  : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= '0;
            err_q  <= '0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign done_cnt = done_q;
    assign err_cnt  = err_q;

endmodule

// File: rtl/design_18_issuer.sv
// design_18_issuer: issues operand pairs to a start/valid engine and returns results with timeout
module design_18_issuer
    import design_18_pkg::*;
#(
    parameter int W       = 16,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          eng_start,
    output logic [W-1:0]  eng_a,
    output logic [W-1:0]  eng_b,
    input  logic [W-1:0]  eng_y,
    input  logic          eng_valid,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_y,
    output logic          res_err,
    output logic [CW-1:0] done_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          busy
);

    localparam int WCW = $clog2(TIMEOUT);
    localparam logic [WCW-1:0] LAST = WCW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
    logic           err_q, err_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           done_p, err_p;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        done_p  = 1'b0;
        err_p   = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                state_d = ISSUE;
            end
            ISSUE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            // a result arriving in the final wait cycle still counts as success
            WAIT: if (eng_valid) begin
                y_d     = eng_y;
                err_d   = 1'b0;
                done_p  = 1'b1;
                state_d = HOLD;
            end else if (wcnt_q == LAST) begin
                y_d     = '0;
                err_d   = 1'b1;
                err_p   = 1'b1;
                state_d = HOLD;
            end else begin
                wcnt_d = wcnt_q + WCW'(1);
            end
            HOLD: if (res_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    design_18_issuer_stat #(.CW(CW)) u_stat (
        .clk      (clk),
        .rst_n    (rst_n),
        .done_inc (done_p),
        .err_inc  (err_p),
        .done_cnt (done_cnt),
        .err_cnt  (err_cnt)
    );

    assign in_ready  = (state_q == IDLE);
    assign eng_start = (state_q == ISSUE);
    assign res_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign eng_a     = a_q;
    assign eng_b     = b_q;
    assign res_y     = y_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_design_18_issuer.sv
// tb_design_18_issuer: directed scoreboard bench with a behavioural engine model
module tb_design_18_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic        eng_start;
    logic [15:0] eng_a, eng_b, eng_y = '0;
    logic        eng_valid = 1'b0;
    logic        res_valid, res_ready = 1'b0;
    logic [15:0] res_y;
    logic        res_err;
    logic [3:0]  done_cnt, err_cnt;
    logic        busy;

    int          n_chk = 0, n_err = 0;
    int          exp_done = 0, exp_err = 0;
    logic [16:0] expq[$];

    design_18_issuer #(.W(16), .TIMEOUT(32), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_y     (eng_y),
        .eng_valid (eng_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_err   (res_err),
        .done_cnt  (done_cnt),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_a", eng_a, 0);
        chk("rst_eng_b", eng_b, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
    endtask

    // lat: WAIT-relative cycle (1..32) in which the engine answers; outside that range it times out
    task automatic op(input logic [15:0] a, input logic [15:0] b, input int lat,
                      input logic [15:0] y, input int hold, input bit pend);
        bit          err;
        int          k;
        logic [16:0] e;
        err = (lat < 1) || (lat > 32);
        expq.push_back({err, err ? 16'h0 : y});
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        chk("eng_start_issue", eng_start, 1);
        chk("eng_a_issue", eng_a, a);
        chk("eng_b_issue", eng_b, b);
        chk("busy_issue", busy, 1);
        k = 0;
        while (!res_valid && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("eng_start_pulse", eng_start, 0);
            eng_valid = (k == lat);
            eng_y = (k == lat) ? y : 16'h0;
        end
        chk("latency", k, err ? 33 : lat + 1);
        e = expq.pop_front();
        if (!res_valid) begin
            eng_valid = 1'b0;
            return;
        end
        if (err) exp_err = (exp_err == 15) ? 15 : exp_err + 1;
        else exp_done = (exp_done == 15) ? 15 : exp_done + 1;
        for (int i = 0; i <= hold; i++) begin
            chk("res_valid_hold", res_valid, 1);
            chk("res_y", res_y, e[15:0]);
            chk("res_err", res_err, e[16]);
            chk("in_ready_hold", in_ready, 0);
            chk("eng_a_hold", eng_a, a);
            if (pend) begin
                in_valid = 1'b1;
                in_a = 16'h1111;
                in_b = 16'h2222;
            end
            eng_valid = 1'b0;
            res_ready = (i == hold);
            @(negedge clk);
        end
        res_ready = 1'b0;
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
        chk("done_cnt", done_cnt, exp_done);
        chk("err_cnt", err_cnt, exp_err);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs();

        op(16'h0005, 16'h0006, 0, 16'h0000, 0, 1'b0);
        op(16'h0003, 16'h0004, 2, 16'h0007, 0, 1'b0);
        op(16'h0010, 16'h0020, 32, 16'hBEEF, 0, 1'b0);
        op(16'h0001, 16'h0001, 33, 16'hAAAA, 0, 1'b0);
        op(16'h0009, 16'h0009, 3, 16'h1234, 10, 1'b1);
        op(16'h1111, 16'h2222, 1, 16'h3333, 0, 1'b0);

        in_valid = 1'b1;
        in_a = 16'h00AA;
        in_b = 16'h00BB;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        exp_done = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        op(16'h0003, 16'h0004, 2, 16'h0007, 0, 1'b0);

        for (int i = 0; i < 20; i++)
            op(16'(i), 16'(i + 1), 1 + i % 3, 16'(i * 3 + 1), 0, 1'b0);
        chk("done_saturated", done_cnt, 15);

        eng_valid = 1'b1;
        eng_y = 16'h5555;
        @(negedge clk);
        eng_valid = 1'b0;
        @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_res_valid", res_valid, 0);
        chk("stray_done_cnt", done_cnt, 15);
        chk("stray_err_cnt", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
